// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX-stage forwarding selects and load-use stall for the 5-stage core
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    // WB is never a forwarding source (write-through register file), so MEM is the last tracked slot.
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_rw;
    logic             r_ex_mr;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_rw;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_cnt;

    logic       w_a_ex;
    logic       w_b_ex;
    logic       w_a_mem;
    logic       w_b_mem;
    logic       w_stall;
    logic       w_bubble;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    assign w_a_ex  = id_use_rs1 && r_ex_rw  && (r_ex_rd  != '0) && (r_ex_rd  == id_rs1);
    assign w_b_ex  = id_use_rs2 && r_ex_rw  && (r_ex_rd  != '0) && (r_ex_rd  == id_rs2);
    assign w_a_mem = id_use_rs1 && r_mem_rw && (r_mem_rd != '0) && (r_mem_rd == id_rs1);
    assign w_b_mem = id_use_rs2 && r_mem_rw && (r_mem_rd != '0) && (r_mem_rd == id_rs2);

    assign w_stall  = id_valid && !flush && r_ex_mr && (w_a_ex || w_b_ex);
    assign w_bubble = w_stall || flush || !id_valid;

    // EX-slot match is checked first so the youngest producer wins.
    assign w_sel_a = w_a_ex ? 2'b10 : (w_a_mem ? 2'b01 : 2'b00);
    assign w_sel_b = w_b_ex ? 2'b10 : (w_b_mem ? 2'b01 : 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd  <= '0;
            r_ex_rw  <= 1'b0;
            r_ex_mr  <= 1'b0;
            r_mem_rd <= '0;
            r_mem_rw <= 1'b0;
            r_fwd_a  <= 2'b00;
            r_fwd_b  <= 2'b00;
        end else begin
            r_mem_rd <= r_ex_rd;
            r_mem_rw <= r_ex_rw;
            if (w_bubble) begin
                r_ex_rd <= '0;
                r_ex_rw <= 1'b0;
                r_ex_mr <= 1'b0;
                r_fwd_a <= 2'b00;
                r_fwd_b <= 2'b00;
            end else begin
                r_ex_rd <= id_rd;
                r_ex_rw <= id_reg_write;
                r_ex_mr <= id_mem_read;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall       = w_stall;
    assign fwd_a_sel   = r_fwd_a;
    assign fwd_b_sel   = r_fwd_b;
    assign stall_count = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit with directed instruction sequences
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       flush = 1'b0;
    logic       cnt_clr = 1'b0;
    logic        stall;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] stall_count;

    logic       rst2 = 1'b1;
    logic       cnt_clr2 = 1'b0;
    logic       stall2;
    logic [1:0] fwd_a2;
    logic [1:0] fwd_b2;
    logic [3:0] cnt2;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count)
    );

    // Small counter instance continuously issuing lw x4,0(x4): stalls every other cycle.
    fwd_hazard_unit #(.REG_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst2), .id_valid(1'b1),
        .id_rs1(5'd4), .id_rs2(5'd0),
        .id_use_rs1(1'b1), .id_use_rs2(1'b0),
        .id_rd(5'd4), .id_reg_write(1'b1), .id_mem_read(1'b1),
        .flush(1'b0), .cnt_clr(cnt_clr2),
        .stall(stall2), .fwd_a_sel(fwd_a2), .fwd_b_sel(fwd_b2),
        .stall_count(cnt2)
    );

    typedef struct packed {
        logic d2;
        int   es;
        int   ea;
        int   eb;
        int   ec;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int es, input int ea, input int eb, input int ec);
        exp_t e;
        e.d2 = 1'b0; e.es = es; e.ea = ea; e.eb = eb; e.ec = ec;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic chk2(input string nm, input int es, input int ec);
        exp_t e;
        e.d2 = 1'b1; e.es = es; e.ea = -1; e.eb = -1; e.ec = ec;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit mr);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        flush        = 1'b0;
        cnt_clr      = 1'b0;
        id_valid     = v;
        id_rs1       = rs1[4:0];
        id_use_rs1   = u1;
        id_rs2       = rs2[4:0];
        id_use_rs2   = u2;
        id_rd        = rd[4:0];
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic nop();
        step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        step(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic ld(input int rd, input int rs1);
        step(1'b1, rs1, 1'b1, 0, 1'b0, rd, 1'b1, 1'b1);
    endtask

    task automatic rnd();
        step($urandom_range(0, 1) == 1, $urandom_range(0, 31), 1'b1, $urandom_range(0, 31), 1'b1,
             $urandom_range(0, 31), 1'b1, 1'b1);
    endtask

    // Monitor: one expectation per checked cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = q.pop_front();
            nm = nq.pop_front();
            if (!e.d2) begin
                if (e.es >= 0) cmp({nm, ".stall"}, int'(stall), e.es);
                if (e.ea >= 0) cmp({nm, ".fwd_a"}, int'(fwd_a_sel), e.ea);
                if (e.eb >= 0) cmp({nm, ".fwd_b"}, int'(fwd_b_sel), e.eb);
                if (e.ec >= 0) cmp({nm, ".count"}, int'(stall_count), e.ec);
            end else begin
                if (e.es >= 0) cmp({nm, ".stall"}, int'(stall2), e.es);
                if (e.ec >= 0) cmp({nm, ".count"}, int'(cnt2), e.ec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec;
        rnd(); rst = 1'b1;
        rnd(); rst = 1'b1; chk("reset", 0, 0, 0, 0);
        alu(3, 1, 2);      chk("first_add", 0, 0, 0, 0);
        alu(5, 1, 2);      chk("first_add_sel", 0, 0, 0, 0);
        alu(6, 5, 5);      chk("b2b_nostall", 0, -1, -1, -1);
        nop();             chk("b2b_sel", 0, 2, 2, 0);
        alu(5, 1, 2);      chk("nop_sel", -1, 0, 0, -1);
        alu(7, 1, 2);
        alu(8, 5, 7);      chk("dist2_nostall", 0, -1, -1, -1);
        nop();             chk("dist2_sel", -1, 1, 2, -1);
        alu(5, 1, 2);
        alu(5, 1, 2);
        alu(9, 5, 0);
        nop();             chk("youngest_sel", -1, 2, 0, -1);
        ld(4, 1);          chk("ld_nostall", 0, -1, -1, 0);
        alu(2, 4, 3);      chk("lu_stall", 1, 0, 0, 0);
        alu(2, 4, 3);      chk("lu_release", 0, 0, 0, 1);
        nop();             chk("lu_sel", 0, 1, 0, 1);
        ld(0, 1);
        alu(1, 0, 0);      chk("x0_nostall", 0, -1, -1, -1);
        nop();             chk("x0_sel", -1, 0, 0, -1);
        ld(4, 1);
        step(1'b1, 4, 1'b0, 4, 1'b0, 4, 1'b1, 1'b0);
                           chk("unused_nostall", 0, -1, -1, -1);
        ld(4, 1);
        alu(2, 4, 3); flush = 1'b1;
                           chk("flush_wins", 0, -1, -1, 1);
        alu(6, 2, 4);      chk("flush_after", 0, 0, 0, 1);
        nop();             chk("flush_bubble", -1, 0, 1, 1);
        ld(4, 1);
        alu(2, 4, 3); cnt_clr = 1'b1;
                           chk("clr_stall", 1, -1, -1, 1);
        alu(2, 4, 3);      chk("clr_wins", 0, -1, -1, 0);
        nop();             chk("clr_sel", -1, 1, 0, 0);
        alu(5, 1, 2);
        alu(8, 5, 5); rst = 1'b1;
        alu(8, 5, 5);      chk("post_rst", 0, 0, 0, 0);
        nop();             chk("post_rst_sel", -1, 0, 0, -1);
        ld(4, 1);
        alu(2, 4, 3); rst = 1'b1;
        alu(2, 4, 3);      chk("rst_drops_load", 0, -1, -1, 0);

        nop(); rst2 = 1'b1;
        nop(); rst2 = 1'b1;
        for (int i = 3; i <= 41; i++) begin
            nop();
            rst2     = 1'b0;
            cnt_clr2 = (i == 38);
            if (i <= 38) begin
                ec = (i - 1) / 2 - 1;
                if (ec > 15) ec = 15;
            end else begin
                ec = (i == 41) ? 1 : 0;
            end
            chk2($sformatf("sat_c%0d", i), ((i % 2) == 0 && i >= 4) ? 1 : 0, ec);
        end
        nop(); cnt_clr2 = 1'b0;

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
